kyber_bram_reader: RTL and testbench
====================================

KYBER_BRAM_READER -- requirements
Module: kyber_bram_reader

Interface
REQ-001 Parameters: none; widths fixed (address 9, RAM word 96, stream beat 32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  one-cycle dump request; sampled only in IDLE.
REQ-005 req_state  input  5  controller state at which the dump proceeds.
REQ-006 start_addr  input  9  first RAM address; sampled with req.
REQ-007 word_count  input  10  words to dump; sampled with req.
REQ-008 abort  input  1  terminate dump at any time.
REQ-009 kyber_state  input  5  core controller state.
REQ-010 pause  output  1  pause request to core; registered.
REQ-011 pause_state  output  5  copy of latched req_state; registered.
REQ-012 bram_addr  output  9  RAM read address to core; registered.
REQ-013 kyber_bram  input  96  RAM read data from core; zero when pause=0.
REQ-014 m_data  output  32  stream beat.
REQ-015 m_valid  output  1  beat valid.
REQ-016 m_ready  input  1  sink accepts beat.
REQ-017 m_last  output  1  marks final beat of final word.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on normal completion.

Function
REQ-020 FSM states: IDLE, ARM, READ, CAPT, SEND, FIN.
REQ-021 IDLE, req=1, word_count=0: no pause; go FIN (done pulse next cycle).
REQ-022 IDLE, req=1, word_count!=0: latch req_state, start_addr, count = min(word_count,512); go ARM.
REQ-023 ARM: pause=1, pause_state=latched state; go READ when kyber_state==pause_state; wait indefinitely otherwise.
REQ-024 READ: bram_addr holds current address for one cycle; go CAPT.
REQ-025 CAPT: one cycle; kyber_bram captured into 96-bit holding register on exit edge; go SEND.
REQ-026 SEND: three beats in order [31:0], [63:32], [95:64]; beat advances only on m_valid&&m_ready.
REQ-027 m_valid asserted throughout SEND; m_data stable while m_valid=1 and m_ready=0.
REQ-028 m_last=1 only on third beat of last word.
REQ-029 After third beat accepted: count-1; if nonzero, address+1 modulo 512 (511 wraps to 0), go READ; else go FIN.
REQ-030 FIN: done=1 for one cycle, pause=0; go IDLE.
REQ-031 pause=1 in ARM, READ, CAPT, SEND; 0 in IDLE and FIN.
REQ-032 Minimum 5 cycles per word (READ+CAPT+3 beats) with m_ready held high.
REQ-033 req while busy=1 ignored; no latched value changes.
REQ-034 abort=1 in any non-IDLE state: go IDLE next edge; pause, m_valid drop; no done; abort in IDLE ignored.
REQ-035 abort and final beat handshake same cycle: abort wins; no done.
REQ-036 kyber_state leaving pause_state after ARM has no effect.

Reset
REQ-037 rst=0 forces IDLE immediately, independent of clk.
REQ-038 Reset values: pause=0, pause_state=0, bram_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0; count, address, holding register 0.
REQ-039 Reset mid-dump discards the dump; no done; first post-reset action needs new req.

Verification
REQ-040 start_addr=0x010, word_count=2, req_state=5, kyber_state=5, m_ready=1, RAM[0x10]=0x...A, RAM[0x11]=0x...B -> bram_addr 0x010 then 0x011; six beats low-to-high; m_last on beat 6; done one cycle after; pause 0 after.
REQ-041 start_addr=0x1FF, word_count=2 -> bram_addr 0x1FF then 0x000.
REQ-042 word_count=0 -> pause stays 0, m_valid stays 0, done pulses once.
REQ-043 m_ready toggled 1/0 every cycle -> every beat held stable until accepted; beat count exactly 3 per word.
REQ-044 kyber_state!=req_state 20 cycles, then equal -> pause=1 throughout, no RAM read before match.
REQ-045 abort in SEND beat 2; separately rst=0 in CAPT -> IDLE, pause=0, m_valid=0, no done; later req starts cleanly.

Source files
------------

// File: rtl/kyber_bram_reader_if.sv
// Stream port of the Kyber RAM dump reader.
// master: m_data/m_valid/m_last out, m_ready in; slave: the reverse.
interface kyber_bram_reader_if;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/kyber_bram_reader.sv
// Pauses the Kyber core at a chosen state and streams RAM words as 32-bit beats.
// Ports: clk, rst (async low), req/req_state/start_addr/word_count/abort in,
//   kyber_state/kyber_bram from core, pause/pause_state/bram_addr to core,
//   m (stream master), busy, done.
module kyber_bram_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [4:0]  req_state,
    input  logic [8:0]  start_addr,
    input  logic [9:0]  word_count,
    input  logic        abort,
    input  logic [4:0]  kyber_state,
    output logic        pause,
    output logic [4:0]  pause_state,
    output logic [8:0]  bram_addr,
    input  logic [95:0] kyber_bram,
    kyber_bram_reader_if.master m,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_READ,
        S_CAPT,
        S_SEND,
        S_FIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  count_q;
    logic [8:0]  addr_q;
    logic [95:0] hold_q;
    logic [1:0]  beat_q;
    logic        accept;
    logic        word_end;

    assign accept    = m.m_valid && m.m_ready;
    assign word_end  = accept && (beat_q == 2'd2);
    assign bram_addr = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:
                    if (req)
                        state_nxt = (word_count == 10'd0) ? S_FIN : S_ARM;
                S_ARM:
                    if (kyber_state == pause_state)
                        state_nxt = S_READ;
                S_READ:
                    state_nxt = S_CAPT;
                S_CAPT:
                    state_nxt = S_SEND;
                S_SEND:
                    if (word_end)
                        state_nxt = (count_q == 10'd1) ? S_FIN : S_READ;
                S_FIN:
                    state_nxt = S_IDLE;
                default:
                    state_nxt = S_IDLE;
            endcase
        end
    end

    // pause is computed from the next state so it is a clean flop output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause       <= 1'b0;
            pause_state <= 5'd0;
            addr_q      <= 9'd0;
            count_q     <= 10'd0;
            hold_q      <= 96'd0;
            beat_q      <= 2'd0;
        end else begin
            pause <= (state_nxt == S_ARM)  || (state_nxt == S_READ) ||
                     (state_nxt == S_CAPT) || (state_nxt == S_SEND);
            unique case (state)
                S_IDLE:
                    if (req && word_count != 10'd0) begin
                        pause_state <= req_state;
                        addr_q      <= start_addr;
                        count_q     <= (word_count > 10'd512) ? 10'd512
                                                             : word_count;
                        beat_q      <= 2'd0;
                    end
                S_CAPT: begin
                    hold_q <= kyber_bram;
                    beat_q <= 2'd0;
                end
                S_SEND:
                    if (accept && !abort) begin
                        if (beat_q == 2'd2) begin
                            beat_q  <= 2'd0;
                            count_q <= count_q - 10'd1;
                            // 9-bit add wraps 511 back to 0
                            if (count_q != 10'd1)
                                addr_q <= addr_q + 9'd1;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                default: ;
            endcase
        end
    end

    always_comb begin
        m.m_valid = (state == S_SEND);
        m.m_last  = (state == S_SEND) && (beat_q == 2'd2) &&
                    (count_q == 10'd1);
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        m.m_data  = 32'd0;
        if (state == S_SEND) begin
            unique case (beat_q)
                2'd0:    m.m_data = hold_q[31:0];
                2'd1:    m.m_data = hold_q[63:32];
                2'd2:    m.m_data = hold_q[95:64];
                default: m.m_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_bram_reader.sv
// Self-checking bench for kyber_bram_reader: vector table, random dumps,
// reset and abort sequences against a word-list reference model.
module tb_kyber_bram_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [4:0]  req_state = '0;
    logic [8:0]  start_addr = '0;
    logic [9:0]  word_count = '0;
    logic        abort = 1'b0;
    logic [4:0]  kyber_state = '0;
    logic        pause;
    logic [4:0]  pause_state;
    logic [8:0]  bram_addr;
    logic [95:0] kyber_bram;
    logic        busy;
    logic        done;

    kyber_bram_reader_if sif ();

    kyber_bram_reader dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_state   (req_state),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .abort       (abort),
        .kyber_state (kyber_state),
        .pause       (pause),
        .pause_state (pause_state),
        .bram_addr   (bram_addr),
        .kyber_bram  (kyber_bram),
        .m           (sif),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [95:0] ram [512];

    // core RAM: one-cycle read latency, zero output while not paused
    always @(posedge clk or negedge rst) begin
        if (!rst) kyber_bram <= '0;
        else      kyber_bram <= pause ? ram[bram_addr] : 96'd0;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0] sa;
        logic [9:0] wc;
        logic [4:0] rs;
        int         rmode;
        int         mism;
        int         abort_beat;
        int         exp_beats;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [8:0]  addr;
    } beat_t;

    task automatic run_dump(input vec_t v, input bit noise);
        beat_t       q[$];
        beat_t       e;
        logic [95:0] w;
        logic [31:0] pd = '0;
        int n, nacc = 0, dones = 0, cyc = 0;
        bit aborted = 0, pseen = 0, pv = 0, pacc = 0, fin = 0;
        int a;

        n = (v.wc > 512) ? 512 : int'(v.wc);
        for (int i = 0; i < n; i++) begin
            a = (int'(v.sa) + i) % 512;
            w = ram[a];
            for (int b = 0; b < 3; b++) begin
                e.data = w[32*b +: 32];
                e.last = (i == n - 1) && (b == 2);
                e.addr = 9'(a);
                q.push_back(e);
            end
        end

        @(negedge clk);
        req = 1'b1;
        start_addr = v.sa;
        word_count = v.wc;
        req_state = v.rs;
        kyber_state = (v.mism > 0) ? (v.rs ^ 5'h1) : v.rs;
        abort = 1'b0;
        sif.m_ready = (v.rmode == 1) ? 1'b0 : 1'b1;

        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            req = 1'b0;
            if (aborted) begin
                chk("abort_busy", {95'd0, busy}, 96'd0);
                chk("abort_pause", {95'd0, pause}, 96'd0);
                chk("abort_valid", {95'd0, sif.m_valid}, 96'd0);
                abort = 1'b0;
            end
            if (done) dones++;
            if (pause) pseen = 1;
            if (v.mism > 0 && cyc <= v.mism) begin
                chk("arm_pause", {95'd0, pause}, 96'd1);
                chk("arm_novalid", {95'd0, sif.m_valid}, 96'd0);
                if (cyc == v.mism) kyber_state = v.rs;
            end
            if (pv && !pacc)
                chk("hold_data", {64'd0, sif.m_data}, {64'd0, pd});
            if (!busy) begin
                fin = 1;
            end else begin
                case (v.rmode)
                    0:       sif.m_ready = 1'b1;
                    1:       sif.m_ready = ~sif.m_ready;
                    default: sif.m_ready = 1'($urandom % 2);
                endcase
                if (noise) begin
                    if ($urandom % 6 == 0) begin
                        req = 1'b1;
                        start_addr = 9'($urandom);
                        word_count = 10'($urandom);
                        req_state = 5'($urandom);
                    end
                    if (nacc > 0) kyber_state = 5'($urandom);
                end
                pv = sif.m_valid;
                pd = sif.m_data;
                pacc = 0;
                if (sif.m_valid) begin
                    chk("valid_pause", {95'd0, pause}, 96'd1);
                    if (v.abort_beat >= 0 && nacc == v.abort_beat) begin
                        abort = 1'b1;
                        sif.m_ready = 1'b1;
                        aborted = 1;
                        pv = 0;
                    end else if (sif.m_ready) begin
                        pacc = 1;
                        if (q.size() == 0) begin
                            chk("extra_beat", 96'(nacc), 96'(n * 3));
                        end else begin
                            e = q.pop_front();
                            chk("beat_data", {64'd0, sif.m_data},
                                {64'd0, e.data});
                            chk("beat_last", {95'd0, sif.m_last},
                                {95'd0, e.last});
                            chk("beat_addr", {87'd0, bram_addr},
                                {87'd0, e.addr});
                        end
                        nacc++;
                    end
                end
            end
        end
        if (!fin)
            chk("timeout", 96'(cyc), 96'(0));
        chk("beat_count", 96'(nacc), 96'(v.exp_beats));
        chk("done_count", 96'(dones), 96'(v.exp_done));
        chk("pause_seen", {95'd0, pseen}, {95'd0, (v.wc != 10'd0)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_done", {95'd0, done}, 96'd0);
            chk("idle_pause", {95'd0, pause}, 96'd0);
        end
    endtask

    vec_t vt [8];
    vec_t rv;
    int   k;

    initial begin
        sif.m_ready = 1'b0;
        for (int i = 0; i < 512; i++)
            ram[i] = {$urandom, $urandom, $urandom};
        ram[16][3:0] = 4'hA;
        ram[17][3:0] = 4'hB;

        vt[0] = '{9'h010, 10'd2,   5'd5,  0, 0,  -1, 6,    1};
        vt[1] = '{9'h1FF, 10'd2,   5'd3,  0, 0,  -1, 6,    1};
        vt[2] = '{9'h055, 10'd0,   5'd2,  0, 0,  -1, 0,    1};
        vt[3] = '{9'h020, 10'd3,   5'd9,  1, 0,  -1, 9,    1};
        vt[4] = '{9'h100, 10'd1,   5'd12, 0, 20, -1, 3,    1};
        vt[5] = '{9'h030, 10'd2,   5'd4,  0, 0,  1,  1,    0};
        vt[6] = '{9'h1F0, 10'd600, 5'd7,  0, 0,  -1, 1536, 1};
        vt[7] = '{9'h0A0, 10'd4,   5'd1,  2, 3,  -1, 12,   1};

        #12;
        chk("rst_pause", {95'd0, pause}, 96'd0);
        chk("rst_pstate", {91'd0, pause_state}, 96'd0);
        chk("rst_addr", {87'd0, bram_addr}, 96'd0);
        chk("rst_data", {64'd0, sif.m_data}, 96'd0);
        chk("rst_valid", {95'd0, sif.m_valid}, 96'd0);
        chk("rst_last", {95'd0, sif.m_last}, 96'd0);
        chk("rst_busy", {95'd0, busy}, 96'd0);
        chk("rst_done", {95'd0, done}, 96'd0);
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort", {95'd0, busy}, 96'd0);

        for (int i = 0; i < 8; i++)
            run_dump(vt[i], 1'b0);

        @(negedge clk);
        req = 1'b1;
        start_addr = 9'h040;
        word_count = 10'd3;
        req_state = 5'd7;
        kyber_state = 5'd7;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", {95'd0, busy}, 96'd0);
        chk("mid_rst_pause", {95'd0, pause}, 96'd0);
        chk("mid_rst_valid", {95'd0, sif.m_valid}, 96'd0);
        chk("mid_rst_addr", {87'd0, bram_addr}, 96'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", {95'd0, done}, 96'd0);
            chk("post_rst_busy", {95'd0, busy}, 96'd0);
        end
        run_dump(vt[0], 1'b0);

        for (int r = 0; r < 12; r++) begin
            k = int'($urandom_range(0, 8));
            rv.sa = 9'($urandom);
            rv.wc = 10'(k);
            rv.rs = 5'($urandom);
            rv.rmode = 2;
            rv.mism = int'($urandom_range(0, 3));
            rv.abort_beat = -1;
            rv.exp_beats = 3 * k;
            rv.exp_done = 1;
            if (k == 0) rv.mism = 0;
            run_dump(rv, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
